// File: rtl/cam_search_ctrl.sv
// Sequencer/arbiter for a linear-scan CAM in external synchronous-read RAM.
// One write requester (absolute priority) and two round-robin search requesters.
module cam_search_ctrl #(
  parameter int DATA_W = 5,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [DATA_W-1:0] key0,
  input  logic              req1,
  input  logic [DATA_W-1:0] key1,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              grant0,
  output logic              grant1,
  output logic              wr_ack,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              busy,
  output logic              done,
  output logic              done_id,
  output logic              found,
  output logic [ADDR_W-1:0] match_addr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, WRITE, SCAN, DONE} state_t;

  state_t            state, state_nx;
  logic              rr_last;
  logic              srv_id;
  logic [DATA_W-1:0] key_q;
  logic              cmp_vld;
  logic [ADDR_W-1:0] cmp_addr;
  logic              take_wr, take_srch, sel, hit, scan_end;
  logic              rd_en_d;
  logic [ADDR_W-1:0] rd_addr_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // WRITE and DONE fall straight into arbitration so a new grant can follow
  // their one-cycle pulse immediately; WRITE masks the write it just acknowledged.
  always_comb begin
    take_wr   = (state != SCAN) && wr_req && (state != WRITE);
    take_srch = (state != SCAN) && !take_wr && (req0 || req1);
    sel       = req1 && (!req0 || !rr_last);
    hit       = (state == SCAN) && cmp_vld && (mem_rd_data == key_q);
    scan_end  = hit || ((state == SCAN) && cmp_vld && (cmp_addr == LAST));
    state_nx  = state;
    unique case (state)
      SCAN:    if (scan_end) state_nx = DONE;
      default: begin
        if (take_wr)        state_nx = WRITE;
        else if (take_srch) state_nx = SCAN;
        else                state_nx = IDLE;
      end
    endcase
  end

  // Read issue: address 0 the cycle after the grant, then one per cycle until
  // a hit or the last entry has been issued.
  always_comb begin
    rd_en_d   = 1'b0;
    rd_addr_d = mem_rd_addr;
    if (grant0 || grant1) begin
      rd_en_d   = 1'b1;
      rd_addr_d = '0;
    end else if ((state == SCAN) && mem_rd_en && !hit && (mem_rd_addr != LAST)) begin
      rd_en_d   = 1'b1;
      rd_addr_d = mem_rd_addr + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_last     <= 1'b1;
      srv_id      <= 1'b0;
      key_q       <= '0;
      cmp_vld     <= 1'b0;
      cmp_addr    <= '0;
      grant0      <= 1'b0;
      grant1      <= 1'b0;
      wr_ack      <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      done_id     <= 1'b0;
      found       <= 1'b0;
      match_addr  <= '0;
    end else begin
      grant0    <= take_srch && !sel;
      grant1    <= take_srch && sel;
      wr_ack    <= take_wr;
      mem_wr_en <= take_wr;
      if (take_wr) begin
        mem_wr_addr <= wr_addr;
        mem_wr_data <= wr_data;
      end
      if (take_srch) begin
        key_q   <= sel ? key1 : key0;
        srv_id  <= sel;
        rr_last <= sel;
      end
      mem_rd_en   <= rd_en_d;
      mem_rd_addr <= rd_addr_d;
      cmp_vld     <= mem_rd_en;
      cmp_addr    <= mem_rd_addr;
      busy        <= (state_nx != IDLE);
      done        <= scan_end;
      if (scan_end) begin
        done_id    <= srv_id;
        found      <= hit;
        match_addr <= hit ? cmp_addr : '0;
      end
    end
  end

endmodule

// File: tb/tb_cam_search_ctrl.sv
// Directed bench for cam_search_ctrl with a synchronous-read memory model.
module tb_cam_search_ctrl;

  localparam int DW = 5;
  localparam int AW = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, wr_req = 1'b0;
  logic [DW-1:0] key0 = '0, key1 = '0, wr_data = '0;
  logic [AW-1:0] wr_addr = '0;
  logic          grant0, grant1, wr_ack, mem_rd_en, mem_wr_en;
  logic [AW-1:0] mem_rd_addr, mem_wr_addr, match_addr;
  logic [DW-1:0] mem_rd_data, mem_wr_data;
  logic          busy, done, done_id, found;

  logic [DW-1:0] mem [0:DEPTH-1];
  int n_chk = 0;
  int n_pass = 0;

  cam_search_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .key0(key0), .req1(req1), .key1(key1),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .grant0(grant0), .grant1(grant1), .wr_ack(wr_ack),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .busy(busy), .done(done), .done_id(done_id), .found(found), .match_addr(match_addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({grant0, grant1, wr_ack, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr,
                mem_wr_data, busy, done, done_id, found, match_addr});
  endfunction

  // Called on the grant cycle; follows the scan to its done pulse.
  task automatic wait_done(input bit exp_id, input bit exp_found, input int exp_addr);
    int n = 0, reads = 0, maxa = 0, lat, exp_reads, exp_max;
    bit got = 1'b0;
    lat       = exp_found ? exp_addr + 3 : DEPTH + 2;
    exp_reads = exp_found ? exp_addr + 2 : DEPTH;
    exp_max   = exp_found ? exp_addr + 1 : DEPTH - 1;
    check("busy_at_grant", busy, 1);
    while (!got && n < 100) begin
      tick();
      n++;
      if (mem_rd_en) begin
        reads++;
        if (reads == 1) begin
          check("first_rd_cycle", n, 1);
          check("first_rd_addr", mem_rd_addr, 0);
        end
        if (int'(mem_rd_addr) > maxa) maxa = int'(mem_rd_addr);
      end
      got = done;
    end
    check("done_latency", n, lat);
    check("found", found, exp_found);
    check("match_addr", match_addr, exp_found ? exp_addr : 0);
    check("done_id", done_id, exp_id);
    check("read_count", reads, exp_reads);
    check("max_rd_addr", maxa, exp_max);
    check("busy_in_done", busy, 1);
    tick();
    check("done_pulse", done, 0);
    check("found_held", found, exp_found);
  endtask

  task automatic run_search(input bit id, input logic [DW-1:0] key,
                            input bit exp_found, input int exp_addr);
    bit got = 1'b0;
    if (id) begin req1 = 1'b1; key1 = key; end
    else    begin req0 = 1'b1; key0 = key; end
    for (int n = 0; n < 50 && !got; n++) begin
      tick();
      got = id ? grant1 : grant0;
    end
    check("grant", got, 1);
    req0 = 1'b0; req1 = 1'b0;
    key0 = ~key; key1 = ~key;
    wait_done(id, exp_found, exp_addr);
    check("idle_after", busy, 0);
  endtask

  task automatic write_entry(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit got = 1'b0;
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    for (int n = 0; n < 50 && !got; n++) begin
      tick();
      got = wr_ack;
    end
    check("wr_ack", got, 1);
    check("wr_en", mem_wr_en, 1);
    check("wr_addr", mem_wr_addr, a);
    wr_req = 1'b0;
    tick();
    check("wr_ack_pulse", wr_ack, 0);
  endtask

  initial begin
    int gc[4], gid[4], did[4], dm[4];
    int ng = 0, nd = 0;
    bit got;
    for (int i = 0; i < DEPTH; i++) mem[i] = 5'd31;
    mem[0] = 5'd5; mem[1] = 5'd6; mem[2] = 5'd2;
    mem[3] = 5'd3; mem[4] = 5'd1; mem[5] = 5'd0;

    #3 rst = 1'b0;
    tick(); tick();
    check("reset_outputs", all_outs(), 0);
    rst = 1'b1;
    tick();

    run_search(1'b0, 5'd3, 1'b1, 3);
    run_search(1'b1, 5'd7, 1'b0, 0);

    // Both requesters held: round-robin order and back-to-back grant spacing.
    rst = 1'b0; tick(); rst = 1'b1;
    req0 = 1'b1; key0 = 5'd5; req1 = 1'b1; key1 = 5'd0;
    for (int t = 0; t < 200 && nd < 4; t++) begin
      tick();
      if (grant0 || grant1) begin
        if (ng < 4) begin gid[ng] = int'(grant1); gc[ng] = t; end
        ng++;
      end
      if (done) begin
        if (nd < 4) begin did[nd] = int'(done_id); dm[nd] = int'(match_addr); end
        nd++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("rr_done_count", nd, 4);
    check("rr_grant_count", ng, 4);
    for (int i = 0; i < 4 && nd == 4 && ng == 4; i++) begin
      check("rr_grant_id", gid[i], i % 2);
      check("rr_done_id", did[i], i % 2);
      check("rr_match", dm[i], (i % 2) ? 5 : 0);
      if (i < 3) check("rr_grant_gap", gc[i+1] - gc[i], (i % 2) ? 9 : 4);
    end
    tick(); tick();

    // Write beats a simultaneous search, which is granted the next cycle.
    wr_req = 1'b1; wr_addr = 5'd10; wr_data = 5'd7;
    req0 = 1'b1; key0 = 5'd7;
    tick();
    check("wr_first_ack", wr_ack, 1);
    check("wr_first_en", mem_wr_en, 1);
    check("wr_first_addr", mem_wr_addr, 10);
    check("wr_first_data", mem_wr_data, 7);
    check("wr_first_nogrant", grant0, 0);
    wr_req = 1'b0;
    tick();
    check("grant_after_wr", grant0, 1);
    check("wr_ack_cleared", wr_ack, 0);
    req0 = 1'b0; key0 = 5'd0;
    wait_done(1'b0, 1'b1, 10);

    // Duplicate entries at 2 and 3: lowest wins.
    write_entry(5'd2, 5'd3);
    run_search(1'b1, 5'd3, 1'b1, 2);

    // Reset in the middle of a scan, request still pending.
    req1 = 1'b1; key1 = 5'd1;
    got = 1'b0;
    for (int n = 0; n < 50 && !got; n++) begin
      tick();
      got = grant1;
    end
    check("pre_reset_grant", got, 1);
    tick(); tick(); tick();
    rst = 1'b0;
    #1;
    check("midscan_reset_outputs", all_outs(), 0);
    tick(); tick();
    rst = 1'b1;
    run_search(1'b1, 5'd1, 1'b1, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
